// File: rtl/axis_eth_tx_sf_fifo_pkg.sv
// Shared definitions for the transmit store-and-forward FIFO.
//   wr_state_t    : write-side FSM encoding (also exposed on the debug port)
//   TUSER_BAD_BIT : tuser bit carrying the bad-frame flag; the transmit MAC
//                   uses the same index.
package axis_eth_tx_sf_fifo_pkg;

  localparam int TUSER_BAD_BIT = 0;

  // IDLE_WR is a reserved encoding: the write side idles in WRITE and any
  // stray IDLE_WR value recovers to WRITE on the next clock.
  typedef enum logic [1:0] {
    IDLE_WR = 2'd0,
    WRITE   = 2'd1,
    DROP    = 2'd2
  } wr_state_t;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk     : clock
//   wr_en   : write strobe, writes wr_data at wr_addr
//   rd_en   : read strobe, rd_data <= mem[rd_addr] on the next edge
//   rd_data : holds its value while rd_en is low
// No reset on the array or the read register so it maps onto block RAM.
module eth_sdp_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_eth_tx_sf_fifo.sv
// Store-and-forward frame FIFO in front of the GMII transmit MAC.
// A frame becomes readable only once its tlast beat has been written, so the
// output streams a whole frame without tvalid gaps. Oversize frames and
// (optionally) frames flagged bad on tlast are dropped on the write side.
//   clk, rst           : clock, synchronous active-high reset
//   s_axis_*           : input stream (tuser[0] = bad frame, sampled on tlast)
//   m_axis_*           : output stream to the MAC (tuser only on tlast word)
//   status_good_frame  : 1-cycle pulse, frame committed
//   status_bad_frame   : 1-cycle pulse, frame dropped for tuser bad flag
//   status_overflow    : 1-cycle pulse, frame dropped as oversize
//   status_level       : words buffered, committed plus in-progress
//   dbg_wr_state       : current write FSM state
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; tvalid never waits on tready, and a valid beat is held stable
// until it transfers.
// DEPTH must be a power of two (>= 64) and DATA_WIDTH must be 8.
module axis_eth_tx_sf_fifo
  import axis_eth_tx_sf_fifo_pkg::*;
#(
  parameter int DEPTH          = 4096,
  parameter int DATA_WIDTH     = 8,
  parameter int USER_WIDTH     = 1,
  parameter int DROP_BAD_FRAME = 1,
  parameter int DROP_OVERSIZE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,
  output logic                     status_good_frame,
  output logic                     status_bad_frame,
  output logic                     status_overflow,
  output logic [$clog2(DEPTH):0]   status_level,
  output wr_state_t                dbg_wr_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = 1 + USER_WIDTH + DATA_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  wr_state_t state_q, state_d;

  logic [PW-1:0] wr_ptr_cur, wr_ptr_commit, rd_ptr;
  logic [PW-1:0] occupancy, frame_len;
  logic          full, frame_full, accept, drop_bad, ram_we;
  logic          committed_empty, out_ready, rd_issue, rd_valid;
  logic [RW-1:0] ram_wdata, ram_q;

  assign occupancy = wr_ptr_cur - rd_ptr;
  assign frame_len = wr_ptr_cur - wr_ptr_commit;
  assign full      = (occupancy == DEPTH_P);
  // The frame in progress alone fills the buffer: the next beat makes it
  // oversize, so it must be accepted (and the frame dropped) rather than stalled.
  assign frame_full = (DROP_OVERSIZE != 0) && (frame_len == DEPTH_P);
  assign accept     = s_axis_tvalid && s_axis_tready;
  assign drop_bad   = (DROP_BAD_FRAME != 0) && s_axis_tuser[TUSER_BAD_BIT];

  // Non-tlast words carry zero tuser so the MAC sees the flag only on tlast.
  assign ram_wdata = {s_axis_tlast,
                      s_axis_tlast ? s_axis_tuser : {USER_WIDTH{1'b0}},
                      s_axis_tdata};

  // Write FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WRITE;
    else     state_q <= state_d;
  end

  // Write FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      DROP:    if (accept && s_axis_tlast) state_d = WRITE;
      WRITE:   if (accept && frame_full && !s_axis_tlast) state_d = DROP;
      default: state_d = WRITE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    s_axis_tready = 1'b0;
    ram_we        = 1'b0;
    if (!rst) begin
      case (state_q)
        DROP: s_axis_tready = 1'b1;
        default: begin
          s_axis_tready = !full || frame_full;
          ram_we        = s_axis_tvalid && (!full || frame_full) && !frame_full;
        end
      endcase
    end
  end

  assign dbg_wr_state = state_q;

  // Write pointers and status pulses. A rewind only moves wr_ptr_cur back to
  // wr_ptr_commit, so committed data and rd_ptr are never disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
      if (accept && state_q != DROP) begin
        if (frame_full) begin
          wr_ptr_cur      <= wr_ptr_commit;
          status_overflow <= 1'b1;
        end else if (s_axis_tlast) begin
          if (drop_bad) begin
            wr_ptr_cur       <= wr_ptr_commit;
            status_bad_frame <= 1'b1;
          end else begin
            wr_ptr_cur        <= wr_ptr_cur + 1'b1;
            wr_ptr_commit     <= wr_ptr_cur + 1'b1;
            status_good_frame <= 1'b1;
          end
        end else begin
          wr_ptr_cur <= wr_ptr_cur + 1'b1;
        end
      end
    end
  end

  assign status_level = occupancy;

  eth_sdp_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_cur[AW-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

  // Read pipeline: RAM read register (rd_valid) -> output register (m_axis_*).
  // Both stages advance together whenever the output register can take a
  // word, so one word per cycle flows while m_axis_tready stays high.
  assign committed_empty = (rd_ptr == wr_ptr_commit);
  assign out_ready       = !m_axis_tvalid || m_axis_tready;
  assign rd_issue        = !committed_empty && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      rd_valid      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      if (out_ready) begin
        rd_valid      <= rd_issue;
        m_axis_tvalid <= rd_valid;
        m_axis_tlast  <= rd_valid ? ram_q[RW-1] : 1'b0;
        m_axis_tuser  <= rd_valid ? ram_q[DATA_WIDTH +: USER_WIDTH] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (out_ready && rd_valid) m_axis_tdata <= ram_q[DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_axis_eth_tx_sf_fifo.sv
module tb_axis_eth_tx_sf_fifo;
  import axis_eth_tx_sf_fifo_pkg::*;

  localparam int DEPTH = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]    s_axis_tdata  = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast  = 1'b0;
  logic [0:0]    s_axis_tuser  = '0;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [0:0]    m_axis_tuser;
  logic          status_good_frame, status_bad_frame, status_overflow;
  logic [LW-1:0] status_level;
  wr_state_t     dbg_wr_state;

  axis_eth_tx_sf_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(8), .USER_WIDTH(1),
    .DROP_BAD_FRAME(1), .DROP_OVERSIZE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .status_good_frame(status_good_frame), .status_bad_frame(status_bad_frame),
    .status_overflow(status_overflow), .status_level(status_level),
    .dbg_wr_state(dbg_wr_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // m_axis_tready: either a commanded level or random toggling
  logic m_tready_cmd = 1'b0;
  bit   rand_en      = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_en) m_axis_tready = 1'($urandom_range(0, 1));
    else         m_axis_tready = m_tready_cmd;
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collects accepted input beats per frame and decides
  // the fate of the whole frame from its length and its tlast flag.
  logic [9:0] exp_q[$];
  logic [9:0] frm[$];
  int  frm_cnt = 0;
  bit  frm_drop = 0;
  int  exp_good = 0, exp_bad = 0, exp_ovf = 0;
  int  dut_good = 0, dut_bad = 0, dut_ovf = 0;
  int  out_beats = 0;
  bit  out_mid = 0;
  bit  prev_mvalid = 0;
  int  tlast_edge = 0, first_valid_cyc = 0, ovf_beat = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      frm.delete();
      frm_cnt = 0;
      frm_drop = 0;
      out_mid = 0;
      prev_mvalid = 0;
    end else begin
      if (status_good_frame) dut_good++;
      if (status_bad_frame)  dut_bad++;
      if (status_overflow) begin
        dut_ovf++;
        ovf_beat = frm_cnt;
      end
      if (m_axis_tvalid && !prev_mvalid) first_valid_cyc = cyc;
      prev_mvalid = m_axis_tvalid;
      if (out_mid) check("no_gap", 32'(m_axis_tvalid), 32'd1);
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h, want none (t=%0t)",
                   {m_axis_tlast, m_axis_tuser, m_axis_tdata}, $time);
        end else begin
          check("beat", 32'({m_axis_tlast, m_axis_tuser, m_axis_tdata}), 32'(exp_q.pop_front()));
        end
        out_mid = !m_axis_tlast;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        frm_cnt++;
        frm.push_back({s_axis_tlast, s_axis_tlast ? s_axis_tuser : 1'b0, s_axis_tdata});
        if (frm_cnt == DEPTH + 1) begin
          frm_drop = 1;
          exp_ovf++;
        end
        if (s_axis_tlast) begin
          tlast_edge = cyc + 1;
          if (!frm_drop) begin
            if (s_axis_tuser[0]) exp_bad++;
            else begin
              foreach (frm[i]) exp_q.push_back(frm[i]);
              exp_good++;
            end
          end
          frm.delete();
          frm_cnt = 0;
          frm_drop = 0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_hs();
    int budget = 2000;
    bit hs = 0;
    do begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      budget--;
    end while (!hs && budget > 0);
    if (!hs) check("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int len, input bit bad, input logic [7:0] base, input int stop_after);
    for (int i = 0; i < len; i++) begin
      if (i == stop_after) break;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(base + 8'(i));
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = 1'((i == len - 1) && bad);
      wait_hs();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
  endtask

  task automatic wait_drain();
    int b = 3000;
    do begin
      @(posedge clk);
      #1;
      b--;
    end while ((exp_q.size() != 0 || m_axis_tvalid) && b > 0);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_model_counts();
    check("good_vs_model", 32'(dut_good), 32'(exp_good));
    check("bad_vs_model",  32'(dut_bad),  32'(exp_bad));
    check("ovf_vs_model",  32'(dut_ovf),  32'(exp_ovf));
  endtask

  int  cur_frame_idx = 0;
  int  ob0, g0, b0, o0;
  bit  stalled;

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready",  32'(s_axis_tready), 32'd0);
    check("rst_m_tvalid",  32'(m_axis_tvalid), 32'd0);
    check("rst_m_tlast",   32'(m_axis_tlast),  32'd0);
    check("rst_m_tuser",   32'(m_axis_tuser),  32'd0);
    check("rst_level",     32'(status_level),  32'd0);
    check("rst_pulses",    32'({status_good_frame, status_bad_frame, status_overflow}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", 32'(s_axis_tready), 32'd1);
    @(posedge clk);
    #1;
    m_tready_cmd = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 60-byte frame, 0x00..0x3B
    ob0 = out_beats; g0 = dut_good;
    send_frame(60, 0, 8'h00, 1000);
    wait_drain();
    check("t1_beats",   32'(out_beats - ob0), 32'd60);
    check("t1_latency", 32'(first_valid_cyc - tlast_edge), 32'd2);
    check("t1_good",    32'(dut_good - g0), 32'd1);
    check_model_counts();

    // bad frame dropped, then a good 10-byte frame
    ob0 = out_beats; b0 = dut_bad; g0 = dut_good;
    send_frame(20, 1, 8'h40, 1000);
    repeat (4) @(posedge clk);
    #1;
    check("t2_level",     32'(status_level), 32'd0);
    check("t2_bad",       32'(dut_bad - b0), 32'd1);
    check("t2_no_output", 32'(out_beats - ob0), 32'd0);
    send_frame(10, 0, 8'h80, 1000);
    wait_drain();
    check("t2_beats", 32'(out_beats - ob0), 32'd10);
    check("t2_good",  32'(dut_good - g0), 32'd1);
    check_model_counts();

    // 100-byte oversize frame, then an 8-byte frame
    ob0 = out_beats; o0 = dut_ovf;
    send_frame(100, 0, 8'h10, 1000);
    repeat (4) @(posedge clk);
    #1;
    check("t3_ovf",       32'(dut_ovf - o0), 32'd1);
    check("t3_ovf_beat",  32'(ovf_beat), 32'd65);
    check("t3_no_output", 32'(out_beats - ob0), 32'd0);
    check("t3_level",     32'(status_level), 32'd0);
    send_frame(8, 0, 8'hE0, 1000);
    wait_drain();
    check("t3_beats", 32'(out_beats - ob0), 32'd8);
    check_model_counts();

    // three 30-byte frames with the output blocked
    ob0 = out_beats; g0 = dut_good; b0 = dut_bad; o0 = dut_ovf;
    m_tready_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        for (int k = 1; k <= 3; k++) begin
          cur_frame_idx = k;
          send_frame(30, 0, 8'(k * 30), 1000);
        end
      end
      begin
        int b = 1000;
        stalled = 0;
        while (!stalled && b > 0) begin
          @(negedge clk);
          if (s_axis_tvalid && !s_axis_tready) stalled = 1;
          b--;
        end
        check("t4_stall_seen", 32'(stalled), 32'd1);
        check("t4_level",      32'(status_level), 32'd64);
        check("t4_frame",      32'(cur_frame_idx), 32'd3);
        m_tready_cmd = 1'b1;
      end
    join
    wait_drain();
    check("t4_beats", 32'(out_beats - ob0), 32'd90);
    check("t4_good",  32'(dut_good - g0), 32'd3);
    check("t4_drops", 32'((dut_bad - b0) + (dut_ovf - o0)), 32'd0);
    check_model_counts();

    // random output back-pressure on a 1-byte and a 64-byte frame
    ob0 = out_beats;
    rand_en = 1'b1;
    send_frame(1, 0, 8'hA5, 1000);
    wait_drain();
    check("t5_single", 32'(out_beats - ob0), 32'd1);
    send_frame(64, 0, 8'h33, 1000);
    wait_drain();
    check("t5_beats", 32'(out_beats - ob0), 32'd65);
    rand_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model_counts();

    // reset mid-frame with a committed frame still buffered
    m_tready_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(5, 0, 8'hC0, 1000);
    repeat (4) @(posedge clk);
    #1;
    check("t6_pre_valid", 32'(m_axis_tvalid), 32'd1);
    send_frame(20, 0, 8'hD0, 10);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tready_in_rst", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    check("t6_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_level",    32'(status_level), 32'd0);
    rst = 1'b0;
    m_tready_cmd = 1'b1;
    ob0 = out_beats; g0 = dut_good;
    repeat (50) @(posedge clk);
    #1;
    check("t6_no_output", 32'(out_beats - ob0), 32'd0);
    check("t6_no_pulse",  32'(dut_good - g0), 32'd0);
    check_model_counts();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
